// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: next-PC operation codes and FSM states.
// S_ERR exists only when PC_MISALIGN_CHECK_EN is defined.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_REG    = 2'b11
  } npc_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3
`ifdef PC_MISALIGN_CHECK_EN
    ,
    S_ERR  = 3'd4
`endif
  } state_e;

`ifdef PC_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
`endif

endpackage

// File: rtl/pc_sequencer_pc_target_calc.sv
// Combinational next-PC calculation for PLUS4 / BRANCH / JUMP / REG.
module pc_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  npc_op_e     npc_op,
  input  logic [25:0] imm,
  input  logic [31:0] rd1,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;

  assign seq_pc = pc + 32'd4;
  // Branch offset is a sign-extended word count, hence the two zero LSBs.
  assign br_off = {{14{imm[15]}}, imm[15:0], 2'b00};

  always_comb begin
    npc = seq_pc;
    unique case (npc_op)
      NPC_PLUS4:  npc = seq_pc;
      NPC_BRANCH: npc = seq_pc + br_off;
      NPC_JUMP:   npc = {seq_pc[31:28], imm, 2'b00};
      NPC_REG:    npc = rd1;
      default:    npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and instruction-fetch sequencer over a req/gnt/rvalid memory port.
// Optional PC_MISALIGN_CHECK_EN adds misalign_err and an error state for unaligned PCs.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        instr_ack,
  input  logic [1:0]  npc_op,
  input  logic [25:0] imm,
  input  logic [31:0] rd1,
  input  logic        redirect,
`ifdef PC_MISALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  input  logic [31:0] redirect_pc
);

  state_e      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] instr_d;
  logic        kill, kill_d;
  logic [31:0] npc;

  pc_target_calc u_target (
    .pc     (pc),
    .npc_op (npc_op_e'(npc_op)),
    .imm    (imm),
    .rd1    (rd1),
    .npc    (npc)
  );

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
    state_d = state;
    pc_d    = pc;
    kill_d  = kill;
    instr_d = instr;
    unique case (state)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) pc_d = redirect_pc;
      end
      S_REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
          if (imem_gnt) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = redirect_pc;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (instr_ack) begin
          pc_d    = npc;
          state_d = S_REQ;
        end
      end
`ifdef PC_MISALIGN_CHECK_EN
      S_ERR: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef PC_MISALIGN_CHECK_EN
    // pc is always aligned outside S_ERR, so an unaligned pc_d means one was just loaded.
    if (misaligned(pc_d)) state_d = S_ERR;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      kill  <= 1'b0;
      instr <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      kill  <= kill_d;
      instr <= instr_d;
    end
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign pc_out      = pc;
  assign pc_plus4    = pc + 32'd4;
`ifdef PC_MISALIGN_CHECK_EN
  assign misalign_err = (state == S_ERR);
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized fetch/ack traffic
// checked against a transaction-level next-PC model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_ack;
  logic [1:0]  npc_op;
  logic [25:0] imm;
  logic [31:0] rd1;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] exp_pc;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .instr_ack   (instr_ack),
    .npc_op      (npc_op),
    .imm         (imm),
    .rd1         (rd1),
    .redirect    (redirect),
`ifdef PC_MISALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the architectural rules, using plain integer arithmetic.
  function automatic logic [31:0] model_npc(input logic [1:0] op, input logic [31:0] pc,
                                            input logic [25:0] im, input logic [31:0] r);
    int          off;
    logic [31:0] res;
    case (op)
      2'd0:    res = pc + 32'd4;
      2'd1: begin
        off = $signed(im[15:0]);
        res = pc + 32'd4 + 32'(off * 4);
      end
      2'd2:    res = ((pc + 32'd4) & 32'hF000_0000) | ({6'b0, im} * 32'd4);
      default: res = r;
    endcase
    return res;
  endfunction

  task automatic wait_req();
    int k = 0;
    while (!imem_req && k < 20) begin
      step();
      k++;
    end
    check("req_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  // Play memory for one fetch: optional grant and response delays, with ignored noise inputs.
  task automatic fetch(input logic [31:0] ea, input logic [31:0] data, input int gd,
                       input int rd, input bit noise);
    wait_req();
    check("req_addr", imem_addr, ea);
    check("req_pc_out", pc_out, ea);
    for (int i = 0; i < gd; i++) begin
      if (noise) begin
        imem_rvalid = 1'($urandom);
        instr_ack   = 1'($urandom);
        imem_rdata  = $urandom;
      end
      step();
      check("req_held", {31'b0, imem_req}, 32'd1);
      check("req_addr_held", imem_addr, ea);
    end
    imem_rvalid = 1'b0;
    instr_ack   = 1'b0;
    imem_gnt    = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("req_drop", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < rd; i++) begin
      if (noise) begin
        imem_gnt  = 1'($urandom);
        instr_ack = 1'($urandom);
      end
      step();
      check("wait_no_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_gnt    = 1'b0;
    instr_ack   = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    check("hold_valid", {31'b0, instr_valid}, 32'd1);
    check("hold_instr", instr, data);
    check("hold_pc", pc_out, ea);
    check("hold_pc_plus4", pc_plus4, ea + 32'd4);
    check("hold_no_req", {31'b0, imem_req}, 32'd0);
  endtask

  task automatic ack(input logic [1:0] op, input logic [25:0] im, input logic [31:0] r,
                     input int hold);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_stays", {31'b0, instr_valid}, 32'd1);
    end
    instr_ack = 1'b1;
    npc_op    = op;
    imm       = im;
    rd1       = r;
    step();
    instr_ack = 1'b0;
    check("ack_clears_valid", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    int start;
    logic [1:0]  op;
    logic [25:0] im;
    logic [31:0] r, rp;

    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ack = 1'b0; npc_op = 2'd0; imm = '0; rd1 = '0;
    redirect = 1'b0; redirect_pc = '0;

    repeat (3) step();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", pc_out, 32'h0000_3000);
    check("rst_pc_plus4", pc_plus4, 32'h0000_3004);
    check("rst_instr", instr, 32'd0);
`ifdef PC_MISALIGN_CHECK_EN
    check("rst_err", {31'b0, misalign_err}, 32'd0);
`endif
    rst = 1'b0;
    check("idle_req", {31'b0, imem_req}, 32'd0);
    step();

    // Zero-wait memory: one instruction every 3 cycles.
    exp_pc = 32'h0000_3000;
    for (int i = 0; i < 4; i++) begin
      start = cyc;
      fetch(exp_pc, $urandom, 0, 0, 1'b0);
      ack(2'd0, '0, '0, 0);
      check("period", 32'(cyc - start), 32'd3);
      exp_pc = exp_pc + 32'd4;
    end

    fetch(32'h0000_3010, $urandom, 0, 0, 1'b0);
    ack(2'd1, 26'h000_FFFE, '0, 0);
    fetch(32'h0000_300C, $urandom, 0, 0, 1'b0);
    ack(2'd2, 26'h000_0400, '0, 0);
    fetch(32'h0000_1000, $urandom, 0, 0, 1'b0);
    ack(2'd3, '0, 32'h0000_4000, 0);
    fetch(32'h0000_4000, $urandom, 0, 0, 1'b0);
    ack(2'd0, '0, '0, 0);

    // Redirect during S_WAIT: late response is discarded, refetch at the target.
    wait_req();
    check("wr_addr", imem_addr, 32'h0000_4004);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_8000;
    step();
    redirect = 1'b0;
    check("wr_pc", pc_out, 32'h0000_8000);
    repeat (3) begin
      step();
      check("wr_no_req", {31'b0, imem_req}, 32'd0);
      check("wr_no_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("wr_dropped", {31'b0, instr_valid}, 32'd0);
    check("wr_refetch", imem_addr, 32'h0000_8000);
    fetch(32'h0000_8000, 32'h1234_5678, 1, 1, 1'b0);
    ack(2'd0, '0, '0, 1);

    // Redirect together with grant in S_REQ.
    wait_req();
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_9000;
    step();
    imem_gnt = 1'b0; redirect = 1'b0;
    check("rg_no_req", {31'b0, imem_req}, 32'd0);
    check("rg_pc", pc_out, 32'h0000_9000);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    check("rg_dropped", {31'b0, instr_valid}, 32'd0);
    check("rg_refetch", imem_addr, 32'h0000_9000);
    fetch(32'h0000_9000, 32'h2222_2222, 0, 2, 1'b0);

    // Redirect and ack in the same cycle: redirect wins.
    instr_ack = 1'b1; npc_op = 2'd0; redirect = 1'b1; redirect_pc = 32'h0000_A000;
    step();
    instr_ack = 1'b0; redirect = 1'b0;
    check("ra_req", {31'b0, imem_req}, 32'd1);
    check("ra_addr", imem_addr, 32'h0000_A000);

    // Redirect in S_REQ without grant retargets the pending request.
    redirect = 1'b1; redirect_pc = 32'h0000_B000;
    step();
    redirect = 1'b0;
    check("rq_req", {31'b0, imem_req}, 32'd1);
    check("rq_addr", imem_addr, 32'h0000_B000);
    fetch(32'h0000_B000, $urandom, 0, 0, 1'b0);
    ack(2'd0, '0, '0, 0);

    // Randomized traffic against the next-PC model.
    exp_pc = 32'h0000_B004;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      im = 26'($urandom);
      r  = $urandom & 32'hFFFF_FFFC;
      fetch(exp_pc, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      if ($urandom_range(0, 4) == 0) begin
        rp = $urandom & 32'hFFFF_FFFC;
        instr_ack = 1'b1; npc_op = op; imm = im; rd1 = r;
        redirect = 1'b1; redirect_pc = rp;
        step();
        instr_ack = 1'b0; redirect = 1'b0;
        exp_pc = rp;
      end else begin
        ack(op, im, r, $urandom_range(0, 2));
        exp_pc = model_npc(op, exp_pc, im, r);
      end
    end

    // Reset with a killed response pending: first response after reset is kept.
    wait_req();
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_C000;
    step();
    imem_gnt = 1'b0; redirect = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check("mid_rst_pc", pc_out, 32'h0000_3000);
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    rst = 1'b0;
    step();
    fetch(32'h0000_3000, 32'hCAFE_F00D, 0, 1, 1'b0);

`ifdef PC_MISALIGN_CHECK_EN
    ack(2'd3, '0, 32'h0000_3002, 0);
    repeat (3) begin
      check("mis_err", {31'b0, misalign_err}, 32'd1);
      check("mis_no_req", {31'b0, imem_req}, 32'd0);
      check("mis_no_valid", {31'b0, instr_valid}, 32'd0);
      check("mis_pc", pc_out, 32'h0000_3002);
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    step();
    redirect = 1'b0;
    check("mis_clear", {31'b0, misalign_err}, 32'd0);
    check("mis_req", {31'b0, imem_req}, 32'd1);
    check("mis_addr", imem_addr, 32'h0000_3000);
    fetch(32'h0000_3000, $urandom, 0, 0, 1'b0);
`else
    ack(2'd3, '0, 32'h0000_3002, 0);
    fetch(32'h0000_3002, $urandom, 0, 0, 1'b0);
    ack(2'd0, '0, '0, 0);
    fetch(32'h0000_3006, $urandom, 0, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch over a request/grant/response handshake to instruction memory.
- Computes the next PC from the core's NPC operation code, immediate and rs value, using the team's standard next-PC encodings.
- Holds each fetched instruction until the core acknowledges it.
- An external redirect (exception or flush) may preempt fetch in any state; a response already in flight when the redirect arrives is discarded.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until granted.
- imem_addr  out  32  fetch address; equals pc_out.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; at most one outstanding.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/pc_out hold a valid instruction.
- instr  out  32  latched instruction.
- pc_out  out  32  current PC.
- pc_plus4  out  32  pc_out + 4.
- instr_ack  in  1  core consumed the instruction; npc_op/imm/rd1 are valid this cycle.
- npc_op  in  2  00 PLUS4, 01 BRANCH, 10 JUMP, 11 REG.
- imm  in  26  immediate field.
- rd1  in  32  rs register value.
- redirect  in  1  flush request.
- redirect_pc  in  32  flush target.

Behaviour:
- All state is updated on the rising edge of clk. Reset is synchronous, active-high.
- Reset: pc=RESET_PC, state=S_IDLE, kill=0, instr=0. Outputs during and after reset: imem_req=0, instr_valid=0.
- States:
  - S_IDLE: always moves to S_REQ on the next cycle. A redirect here loads pc.
  - S_REQ: imem_req=1, imem_addr=pc.
    - gnt without redirect: go to S_WAIT.
    - redirect without gnt: pc<=redirect_pc; stay in S_REQ (address changes before grant).
    - gnt and redirect together: pc<=redirect_pc, kill<=1, go to S_WAIT.
  - S_WAIT: imem_req=0.
    - rvalid with kill=0 and no redirect: instr<=imem_rdata; go to S_HOLD.
    - rvalid with kill=1: drop the data, kill<=0, go to S_REQ.
    - redirect without rvalid: pc<=redirect_pc, kill<=1.
    - redirect with rvalid: drop the data, pc<=redirect_pc, kill<=0, go to S_REQ.
  - S_HOLD: instr_valid=1.
    - redirect (always wins over ack): pc<=redirect_pc; go to S_REQ.
    - instr_ack: pc<=next PC; go to S_REQ.
    - Otherwise hold indefinitely.
- Next PC (combinational, modulo 2^32):
  - PLUS4: pc+4.
  - BRANCH: pc+4 + {sext(imm[15:0]), 2'b00}.
  - JUMP: {pc_plus4[31:28], imm, 2'b00}.
  - REG: rd1.
- Input qualification:
  - imem_rvalid outside S_WAIT is ignored.
  - imem_gnt outside S_REQ is ignored.
  - instr_ack outside S_HOLD is ignored.
- Throughput: with zero-wait memory (gnt in S_REQ, rvalid next cycle, ack on first S_HOLD cycle), one instruction every 3 cycles. Steady-state pc_out advances every 3 cycles.
- rst mid-operation abandons any outstanding response; the first response after reset is not qualified by kill.
- Memory must not return rvalid for a request issued before rst.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_err (1 bit) and state S_ERR.
  - Any next PC or redirect_pc with bits [1:0] != 0 loads pc with the offending value and enters S_ERR.
  - In S_ERR: misalign_err=1, imem_req=0, instr_valid=0.
  - Exit S_ERR only by rst, or by a redirect with an aligned redirect_pc (goes to S_REQ).
- When undefined: no misalign_err port. Bits [1:0] are loaded unchanged and fetch proceeds.

Decomposition:
- NPC op encodings (PLUS4/BRANCH/JUMP/REG) go in the shared control-encoding definitions.
- FSM state constants go in the same shared package.
- Sub-module pc_target_calc: purely combinational, computes next PC from pc, npc_op, imm and rd1.
- FSM, pc register and kill flag stay in pc_sequencer.

Test Plan:
- Reset release, zero-wait memory, ack PLUS4 every HOLD -> imem_addr sequence 0x3000, 0x3004, 0x3008, one per 3 cycles; instr_valid high exactly 1 cycle in 3.
- In HOLD at pc=0x3010, ack BRANCH imm[15:0]=0xFFFE -> next imem_addr=0x300C. Same with JUMP imm=0x0000400 -> 0x00001000.
- Ack REG with rd1=0x0000_4000 -> next imem_addr=0x4000.
- Redirect to 0x8000 while in S_WAIT; memory returns 0xDEADBEEF 4 cycles later -> data dropped, instr_valid stays 0, next request addr=0x8000.
- Redirect and imem_gnt in the same S_REQ cycle -> the granted response is dropped, then a request to redirect_pc follows. Separately, redirect and instr_ack in the same cycle -> redirect_pc wins.
- With PC_MISALIGN_CHECK_EN defined: ack REG rd1=0x3002 -> misalign_err=1, imem_req stays 0; aligned redirect to 0x3000 -> misalign_err=0, request to 0x3000.
